// File: rtl/tb_watchdog_mc.sv
// tb_watchdog_mc: multi-channel cycle watchdog placed at testbench top beside the DUT.
//
// Each channel counts consecutive idle cycles while armed and raises a sticky expiry flag
// once the count reaches its limit. A global cycle counter flags whole-test hangs, and the
// lowest-numbered channel among the first group to expire is recorded.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   en_i           per-channel arm; a disarmed channel has its count cleared
//   kick_i         per-channel activity pulse; restarts that channel's count
//   limit_i        per-channel idle limit, ch i at [i*CNT_W +: CNT_W]; 0 = never expires
//   clr_i          synchronous clear with the same effect as rst
//   expired_o      sticky per-channel expiry flags
//   any_expired_o  OR of expired_o
//   first_vld_o    first_id_o holds a valid channel index
//   first_id_o     index of the first channel to expire
//   cycles_o       saturating cycle count since the last reset/clear
//   global_to_o    sticky global timeout flag
//
// Build option: define WATCHDOG_FATAL_EN to print a FATAL line and end the simulation when
// any expiry or the global timeout first fires. The port list is the same in both builds.

module tb_watchdog_mc #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned CYC_W          = 32,
  parameter int unsigned GLOBAL_TIMEOUT = 1000,
  localparam int unsigned ID_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       kick_i,
  input  logic [NUM_CH*CNT_W-1:0] limit_i,
  input  logic                    clr_i,
  output logic [NUM_CH-1:0]       expired_o,
  output logic                    any_expired_o,
  output logic                    first_vld_o,
  output logic [ID_W-1:0]         first_id_o,
  output logic [CYC_W-1:0]        cycles_o,
  output logic                    global_to_o
);

  // A timeout that cannot be represented in CYC_W bits could never be reached; disable it
  // rather than letting a truncated compare fire early.
  localparam bit GlobalEn = (GLOBAL_TIMEOUT != 0) &&
                            ((CYC_W >= 33) || ((longint'(GLOBAL_TIMEOUT) >> CYC_W) == 0));
  localparam logic [CYC_W-1:0] GlobalTo = CYC_W'(GLOBAL_TIMEOUT);

  logic [CNT_W-1:0]  limit_ch [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] expired_q, expired_d;
  logic [NUM_CH-1:0] rising;
  logic [ID_W-1:0]   rise_id;
  logic              first_vld_q, first_vld_d;
  logic [ID_W-1:0]   first_id_q, first_id_d;
  logic [CYC_W-1:0]  cycles_q, cycles_d;
  logic              global_to_q, global_to_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_limit
    assign limit_ch[g] = limit_i[g*CNT_W +: CNT_W];
  end

  // Per-channel count/expiry next state, in decreasing priority.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      expired_d[i] = expired_q[i];
      if (!en_i[i]) begin
        cnt_d[i] = '0;
      end else if (kick_i[i]) begin
        cnt_d[i] = '0;
      end else if (expired_q[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (limit_ch[i] == '0) begin
        cnt_d[i] = '0;
      end else if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, limit_ch[i]}) begin
        // The >= also covers a limit lowered below the running count.
        expired_d[i] = 1'b1;
        cnt_d[i]     = limit_ch[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign rising = expired_d & ~expired_q;

  // Lowest-numbered rising channel: scan downwards so the lowest index wins.
  always_comb begin
    rise_id = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (rising[i]) rise_id = ID_W'(i);
    end
  end

  always_comb begin
    first_vld_d = first_vld_q;
    first_id_d  = first_id_q;
    if (!first_vld_q && (|rising)) begin
      first_vld_d = 1'b1;
      first_id_d  = rise_id;
    end
  end

  always_comb begin
    cycles_d    = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
    global_to_d = global_to_q;
    if (GlobalEn && (cycles_d == GlobalTo)) global_to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      expired_q   <= '0;
      first_vld_q <= 1'b0;
      first_id_q  <= '0;
      cycles_q    <= '0;
      global_to_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      expired_q   <= expired_d;
      first_vld_q <= first_vld_d;
      first_id_q  <= first_id_d;
      cycles_q    <= cycles_d;
      global_to_q <= global_to_d;
    end
  end

`ifdef WATCHDOG_FATAL_EN
  // Global timeout takes precedence in the report when it fires with a channel.
  always @(posedge clk) begin
    if (!rst && !clr_i) begin
      if (global_to_d && !global_to_q) begin
        $display("[%0t] [TESTBENCH] FATAL: watchdog global timeout (%0d cycles)", $time,
                 GLOBAL_TIMEOUT);
        $finish;
      end else if (|rising) begin
        $display("[%0t] [TESTBENCH] FATAL: watchdog ch%0d expired", $time, rise_id);
        $finish;
      end
    end
  end
`endif

  assign expired_o     = expired_q;
  assign any_expired_o = |expired_q;
  assign first_vld_o   = first_vld_q;
  assign first_id_o    = first_id_q;
  assign cycles_o      = cycles_q;
  assign global_to_o   = global_to_q;

endmodule

// File: tb/tb_tb_watchdog_mc.sv
// Self-checking bench for tb_watchdog_mc (NUM_CH=4, CNT_W=16, CYC_W=32, GLOBAL_TIMEOUT=1000).
// A behavioural model counts idle cycles per channel with plain integers; every clock the DUT
// outputs are compared against it, and directed sequences also compare against constants.

module tb_tb_watchdog_mc;

  localparam int NCH = 4;
  localparam int GTO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = '0;
  logic [3:0]  kick = '0;
  logic [63:0] lim = '0;
  logic        clr = 1'b0;
  logic [3:0]  expired;
  logic        any_expired;
  logic        first_vld;
  logic [1:0]  first_id;
  logic [31:0] cycles;
  logic        global_to;

  int vectors = 0;
  int miscompares = 0;

  // Model state.
  int     m_idle [NCH];
  bit     m_exp  [NCH];
  bit     m_fv;
  int     m_fid;
  longint m_cyc;
  bit     m_gto;

  always #5 clk = ~clk;

  tb_watchdog_mc #(
    .NUM_CH(4), .CNT_W(16), .CYC_W(32), .GLOBAL_TIMEOUT(GTO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .kick_i       (kick),
    .limit_i      (lim),
    .clr_i        (clr),
    .expired_o    (expired),
    .any_expired_o(any_expired),
    .first_vld_o  (first_vld),
    .first_id_o   (first_id),
    .cycles_o     (cycles),
    .global_to_o  (global_to)
  );

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_edge();
    bit newly [NCH];
    int l;
    bit found;
    if (rst || clr) begin
      for (int c = 0; c < NCH; c++) begin m_idle[c] = 0; m_exp[c] = 0; end
      m_fv = 0; m_fid = 0; m_cyc = 0; m_gto = 0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      newly[c] = 0;
      l = int'(lim[c*16 +: 16]);
      if (!en[c] || kick[c]) m_idle[c] = 0;
      else if (!m_exp[c] && l != 0) begin
        m_idle[c] = m_idle[c] + 1;
        if (m_idle[c] >= l) begin m_exp[c] = 1; newly[c] = 1; end
      end
    end
    found = 0;
    for (int c = 0; c < NCH; c++) begin
      if (newly[c] && !found && !m_fv) begin m_fid = c; found = 1; end
    end
    if (found) m_fv = 1;
    if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
    if (m_cyc == GTO) m_gto = 1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] mexp;
    for (int c = 0; c < NCH; c++) mexp[c] = m_exp[c];
    vectors++;
    if (expired !== mexp || any_expired !== (|mexp) || first_vld !== m_fv ||
        first_id !== 2'(m_fid) || cycles !== 32'(m_cyc) || global_to !== m_gto) begin
      miscompares++;
      $display("FAIL %s: got exp=%b any=%b fv=%b id=%0d cyc=%0d gto=%b; want exp=%b any=%b fv=%b id=%0d cyc=%0d gto=%b",
               tag, expired, any_expired, first_vld, first_id, cycles, global_to,
               mexp, |mexp, m_fv, m_fid, m_cyc, m_gto);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; kick = '0;
    step("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  en;
    logic [63:0] lim;
    logic [3:0]  x_exp;
    logic        x_fv;
    logic [1:0]  x_id;
    logic [31:0] x_cyc;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Reset held 3 cycles with all channels armed, then ch0 alone with limit 5.
    for (int k = 0; k < 3; k++) tbl[k] = '{1'b1, 4'hF, 64'd5, 4'h0, 1'b0, 2'd0, 32'd0};
    for (int k = 3; k < 9; k++)
      tbl[k] = '{1'b0, 4'b0001, 64'd5, (k >= 7) ? 4'b0001 : 4'b0000, k >= 7, 2'd0, 32'(k - 2)};

    for (int k = 0; k < 9; k++) begin
      rst = tbl[k].r; en = tbl[k].en; lim = tbl[k].lim; kick = '0; clr = 1'b0;
      step("table");
      vectors++;
      if (expired !== tbl[k].x_exp || any_expired !== (|tbl[k].x_exp) ||
          first_vld !== tbl[k].x_fv || first_id !== tbl[k].x_id ||
          cycles !== tbl[k].x_cyc || global_to !== 1'b0) begin
        miscompares++;
        $display("FAIL table[%0d]: got exp=%b fv=%b id=%0d cyc=%0d gto=%b; want exp=%b fv=%b id=%0d cyc=%0d gto=0",
                 k, expired, first_vld, first_id, cycles, global_to,
                 tbl[k].x_exp, tbl[k].x_fv, tbl[k].x_id, tbl[k].x_cyc);
      end
    end

    // Regular kicks hold off expiry; expiry lands 4 cycles after the last kick.
    do_reset();
    en = 4'b0010; lim = 64'd4 << 16;
    for (int c = 0; c <= 20; c++) begin
      kick = (c % 3 == 2) ? 4'b0010 : 4'b0000;
      step("kick_seq");
      chk("kicked_no_expiry", 32'(expired[1]), 32'd0);
    end
    kick = '0;
    for (int c = 1; c <= 4; c++) begin
      step("after_kick");
      chk("after_last_kick", 32'(expired[1]), (c == 4) ? 32'd1 : 32'd0);
    end

    // Simultaneous expiry reports the lowest channel; a later expiry leaves the record alone.
    do_reset();
    en = 4'b1110; lim = {16'd6, 16'd6, 16'd9, 16'd0};
    for (int c = 1; c <= 9; c++) begin
      step("multi");
      if (c == 5) chk("multi_pre", 32'(expired), 32'h0);
      if (c == 6) begin
        chk("multi_both", 32'(expired), 32'b1100);
        chk("multi_first_id", 32'(first_id), 32'd2);
        chk("multi_first_vld", 32'(first_vld), 32'd1);
      end
      if (c == 9) begin
        chk("multi_ch1", 32'(expired), 32'b1110);
        chk("multi_id_kept", 32'(first_id), 32'd2);
      end
    end

    // Clear on the expiry cycle wins; so does a kick.
    do_reset();
    en = 4'b0001; lim = 64'd5;
    repeat (4) step("pre_clr");
    clr = 1'b1;
    step("clr");
    clr = 1'b0;
    chk("clr_exp", 32'(expired), 32'h0);
    chk("clr_cycles", cycles, 32'd0);
    chk("clr_fv", 32'(first_vld), 32'd0);
    repeat (4) step("pre_kick");
    kick = 4'b0001;
    step("kick_on_expiry");
    kick = '0;
    chk("kick_blocks_expiry", 32'(expired), 32'h0);
    repeat (4) step("post_kick");
    chk("post_kick_not_yet", 32'(expired), 32'h0);
    step("post_kick_expire");
    chk("post_kick_expired", 32'(expired), 32'b0001);

    // Global timeout with no channels armed.
    do_reset();
    en = '0; lim = '0;
    repeat (999) step("global_run");
    chk("global_before", 32'(global_to), 32'd0);
    chk("global_cycles_999", cycles, 32'd999);
    step("global_hit");
    chk("global_at_1000", 32'(global_to), 32'd1);
    chk("global_cycles_1000", cycles, 32'd1000);
    step("global_sticky");
    chk("global_sticky", 32'(global_to), 32'd1);

    // Randomised traffic against the model.
    do_reset();
    en = 4'($urandom);
    for (int c = 0; c < NCH; c++) lim[c*16 +: 16] = 16'($urandom_range(0, 8));
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 99) == 0);
      if (rst || clr) begin
        for (int c = 0; c < NCH; c++) lim[c*16 +: 16] = 16'($urandom_range(0, 8));
      end else if ($urandom_range(0, 29) == 0) begin
        // Lower one nonzero limit, possibly below the running count.
        for (int c = 0; c < NCH; c++)
          if (c == int'($urandom_range(0, 3)) && lim[c*16 +: 16] > 1)
            lim[c*16 +: 16] = 16'($urandom_range(1, int'(lim[c*16 +: 16]) - 1));
      end
      if ($urandom_range(0, 19) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
      for (int c = 0; c < NCH; c++) kick[c] = ($urandom_range(0, 5) == 0);
      step("random");
    end
    rst = 1'b0; clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
